// File: rtl/button_arbiter.sv
// Arbitrates the shared button_pressed resource between a local player and an
// asynchronous remote player: round-robin on ties, frame-bounded hold, cooldown.
module button_arbiter #(
  parameter int HOLD_FRAMES = 30,
  parameter int COOL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       v_tick,
  input  logic       enable,
  input  logic       req1,
  input  logic [1:0] sel1,
  input  logic       req2_async,
  input  logic [1:0] sel2,
  output logic [1:0] button_pressed,
  output logic [1:0] grant,
  output logic       busy,
  output logic       last_winner
);

  localparam int MAX_FRAMES = (HOLD_FRAMES > COOL_FRAMES) ? HOLD_FRAMES : COOL_FRAMES;
  localparam int CW         = $clog2(MAX_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, GRANT1, GRANT2, COOLDOWN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, cnt_inc;
  logic [1:0]    button_nx, grant_nx;
  logic          last_winner_nx;
  logic          req2_meta, req2_s, v_tick_d;
  logic          frame_tick, v1, v2, own_v;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req2_meta <= 1'b0;
      req2_s    <= 1'b0;
      v_tick_d  <= 1'b0;
    end else begin
      req2_meta <= req2_async;
      req2_s    <= req2_meta;
      v_tick_d  <= v_tick;
    end
  end

  assign frame_tick = v_tick & ~v_tick_d;
  assign v1         = req1 & (sel1 != 2'b00);
  assign v2         = req2_s & (sel2 != 2'b00);
  assign own_v      = (state == GRANT1) ? v1 : v2;
  assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    button_nx      = button_pressed;
    grant_nx       = grant;
    last_winner_nx = last_winner;
    if (!enable) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      button_nx = 2'b00;
      grant_nx  = 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (v1 && (!v2 || last_winner)) begin
            state_nx       = GRANT1;
            button_nx      = sel1;
            grant_nx       = 2'b01;
            last_winner_nx = 1'b0;
            cnt_nx         = '0;
          end else if (v2) begin
            state_nx       = GRANT2;
            button_nx      = sel2;
            grant_nx       = 2'b10;
            last_winner_nx = 1'b1;
            cnt_nx         = '0;
          end
        end
        GRANT1, GRANT2: begin
          // A release in the same cycle as a frame tick discards the increment.
          if (!own_v || (frame_tick && (cnt_inc >= CW'(HOLD_FRAMES)))) begin
            state_nx  = COOLDOWN;
            button_nx = 2'b00;
            grant_nx  = 2'b00;
            cnt_nx    = '0;
          end else if (frame_tick) begin
            cnt_nx = cnt_inc;
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt_inc >= CW'(COOL_FRAMES)) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end
        end
        default: begin
          state_nx  = IDLE;
          cnt_nx    = '0;
          button_nx = 2'b00;
          grant_nx  = 2'b00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      button_pressed <= 2'b00;
      grant          <= 2'b00;
      busy           <= 1'b0;
      last_winner    <= 1'b1;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      button_pressed <= button_nx;
      grant          <= grant_nx;
      busy           <= (state_nx != IDLE);
      last_winner    <= last_winner_nx;
    end
  end

endmodule

// File: tb/tb_button_arbiter.sv
// Self-checking bench for button_arbiter: directed scenarios plus randomized
// traffic compared against a frame-level behavioural model.
module tb_button_arbiter;

  localparam int HOLD = 3;
  localparam int COOL = 8;

  logic       clk = 1'b0;
  logic       rst, v_tick, enable, req1, req2_async;
  logic [1:0] sel1, sel2, button_pressed, grant;
  logic       busy, last_winner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  button_arbiter #(.HOLD_FRAMES(HOLD), .COOL_FRAMES(COOL)) dut (
    .clk(clk), .rst(rst), .v_tick(v_tick), .enable(enable),
    .req1(req1), .sel1(sel1), .req2_async(req2_async), .sel2(sel2),
    .button_pressed(button_pressed), .grant(grant), .busy(busy),
    .last_winner(last_winner)
  );

  // Model: who owns the button, whether we are cooling down, frames elapsed.
  int         m_owner;
  bit         m_cool;
  int         m_frames;
  logic [1:0] m_btn;
  logic       m_lw, m_vt_prev, m_r2m, m_r2s;

  task automatic model_reset();
    m_owner = 0; m_cool = 0; m_frames = 0; m_btn = 2'b00;
    m_lw = 1'b1; m_vt_prev = 1'b0; m_r2m = 1'b0; m_r2s = 1'b0;
  endtask

  task automatic model_step();
    bit ft, v1, v2, vown;
    ft = v_tick && !m_vt_prev;
    v1 = req1 && (sel1 != 2'b00);
    v2 = m_r2s && (sel2 != 2'b00);
    if (!enable) begin
      m_owner = 0; m_cool = 0; m_frames = 0; m_btn = 2'b00;
    end else if (m_owner != 0) begin
      vown = (m_owner == 1) ? v1 : v2;
      if (!vown || (ft && m_frames + 1 >= HOLD)) begin
        m_owner = 0; m_cool = 1; m_frames = 0; m_btn = 2'b00;
      end else if (ft) begin
        m_frames++;
      end
    end else if (m_cool) begin
      if (ft) begin
        m_frames++;
        if (m_frames >= COOL) begin m_cool = 0; m_frames = 0; end
      end
    end else if (v1 && (!v2 || m_lw)) begin
      m_owner = 1; m_btn = sel1; m_lw = 1'b0; m_frames = 0;
    end else if (v2) begin
      m_owner = 2; m_btn = sel2; m_lw = 1'b1; m_frames = 0;
    end
    m_vt_prev = v_tick;
    m_r2s     = m_r2m;
    m_r2m     = req2_async;
  endtask

  function automatic logic [5:0] exp_vec();
    logic [1:0] g;
    g = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    return {g, m_btn, (m_owner != 0) || m_cool, m_lw};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {grant, button_pressed, busy, last_winner};
  endfunction

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    v_tick = 1'b1; step();
    v_tick = 1'b0; step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v_tick = 1'b0; enable = 1'b1; req1 = 1'b0; req2_async = 1'b0;
    sel1 = 2'b00; sel2 = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({grant, button_pressed, busy} !== 5'b0 || last_winner !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got g=%b bp=%b busy=%b lw=%b, want g=00 bp=00 busy=0 lw=1",
               grant, button_pressed, busy, last_winner);
    end
  endtask

  task automatic test_p1_grant();
    req1 = 1'b1; sel1 = 2'b01; step();
    n_checks++;
    if ({grant, button_pressed, busy, last_winner} !== 6'b01_01_1_0) begin
      n_fail++;
      $display("FAIL p1_grant: got %b, want 010110", dut_vec());
    end
    req1 = 1'b0; step();
    for (int i = 0; i < COOL; i++) frame();
    n_checks++;
    if ({grant, busy} !== 3'b000 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL p1_cooldown_end: got %b, want %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    sel1 = 2'b01; sel2 = 2'b10;
    req2_async = 1'b1; step(); step();
    req1 = 1'b1; step();
    n_checks++;
    if (grant !== 2'b01 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL tie_first: got grant=%b, want 01", grant);
    end
    req1 = 1'b0; req2_async = 1'b0; step();
    for (int i = 0; i < COOL; i++) frame();
    req2_async = 1'b1; step(); step();
    req1 = 1'b1; step();
    n_checks++;
    if (grant !== 2'b10 || button_pressed !== 2'b10 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL tie_second: got grant=%b bp=%b, want 10/10", grant, button_pressed);
    end
    req1 = 1'b0; req2_async = 1'b0;
  endtask

  task automatic test_hold_limit();
    do_reset();
    req1 = 1'b1; sel1 = 2'b01; step();
    frame(); frame();
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_before_limit: got grant=%b, want 01", grant);
    end
    v_tick = 1'b1; step();
    n_checks++;
    if (grant !== 2'b00 || button_pressed !== 2'b00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_forced_release: got g=%b bp=%b busy=%b, want 00/00/1",
               grant, button_pressed, busy);
    end
    v_tick = 1'b0; step();
    for (int i = 0; i < COOL - 1; i++) frame();
    n_checks++;
    if (grant !== 2'b00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_cooldown_early: got g=%b busy=%b, want 00/1", grant, busy);
    end
    frame();
    n_checks++;
    if (grant !== 2'b01 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL hold_regrant: got grant=%b, want 01", grant);
    end
    req1 = 1'b0;
  endtask

  task automatic test_p2_latch();
    do_reset();
    sel2 = 2'b11;
    #2 req2_async = 1'b1;
    for (int i = 0; i < 3 && grant !== 2'b10; i++) step();
    n_checks++;
    if (grant !== 2'b10 || button_pressed !== 2'b11) begin
      n_fail++;
      $display("FAIL p2_latency: got g=%b bp=%b within 3 edges, want 10/11", grant, button_pressed);
    end
    sel2 = 2'b01; step(); step();
    n_checks++;
    if (button_pressed !== 2'b11 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL p2_sel_ignored: got bp=%b, want 11", button_pressed);
    end
  endtask

  task automatic test_enable();
    do_reset();
    req1 = 1'b1; sel1 = 2'b10; step();
    enable = 1'b0; step();
    n_checks++;
    if ({grant, button_pressed, busy, last_winner} !== 6'b00_00_0_0) begin
      n_fail++;
      $display("FAIL enable_low: got %b, want 000000", dut_vec());
    end
    step();
    n_checks++;
    if (grant !== 2'b00 || dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("FAIL enable_hold_idle: got %b, want %b", dut_vec(), exp_vec());
    end
    enable = 1'b1; req1 = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    sel2 = 2'b10; req2_async = 1'b1;
    step(); step(); step();
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++;
      $display("FAIL arst_setup: got grant=%b, want 10", grant);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({grant, button_pressed, busy} !== 5'b0 || last_winner !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_immediate: got %b, want 000001", dut_vec());
    end
    model_reset();
    req1 = 1'b1; sel1 = 2'b00; sel2 = 2'b00;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (grant !== 2'b00 || dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL sel_zero_no_grant[%0d]: got %b, want %b", i, dut_vec(), exp_vec());
      end
    end
    req1 = 1'b0; req2_async = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      if ($urandom_range(0, 9) == 0) req2_async = ~req2_async;
      if ($urandom_range(0, 5) == 0) sel1 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) sel2 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) v_tick = ~v_tick;
      enable = ($urandom_range(0, 99) != 0);
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: got g/bp/busy/lw=%b, want %b", i, dut_vec(), exp_vec());
      end
      n_checks++;
      if (grant === 2'b11 || ((button_pressed != 2'b00) != (grant != 2'b00))) begin
        n_fail++;
        $display("FAIL invariant[%0d]: got grant=%b bp=%b, want exclusive and consistent",
                 i, grant, button_pressed);
      end
    end
  endtask

  initial begin
    rst = 1'b1; v_tick = 1'b0; enable = 1'b1; req1 = 1'b0; req2_async = 1'b0;
    sel1 = 2'b00; sel2 = 2'b00;
    model_reset();
    test_reset();
    test_p1_grant();
    test_round_robin();
    test_hold_limit();
    test_p2_latch();
    test_enable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
